// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: multiplies rx by the aligned carrier,
// integrates over one bit and dumps a hard decision each boundary.
//
// Ports:
//   clk_sig, rst_n      clock, async active-low reset
//   sample_en           qualifies rx_sig, carrier_sig, bit_sync
//   rx_sig, carrier_sig 16-bit signed samples
//   bit_sync            current sample is the first of a bit
//   demod_bit/valid     decision and its one-cycle strobe
//   sync_err            bit_sync seen off the expected boundary
//   busy                FSM has left IDLE
module bpsk_demod #(
  parameter int SAMPLES_PER_BIT = 32,
  parameter int ACC_W = 40
) (
  input  logic        clk_sig,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [15:0] rx_sig,
  input  logic [15:0] carrier_sig,
  input  logic        bit_sync,
  output logic        demod_bit,
  output logic        demod_valid,
  output logic        sync_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(SAMPLES_PER_BIT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic accept;
  logic resync;
  logic restart;
  logic first_nxt;
  logic last_nxt;

  logic s1_vld;
  logic s1_first;
  logic s1_last;

  logic signed [31:0] rx_x;
  logic signed [31:0] car_x;
  logic signed [31:0] prod_nxt;
  logic signed [31:0] prod;

  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign busy = (state == RUN);

  assign accept = sample_en & (busy | bit_sync);
  assign resync = busy & bit_sync & (cnt != '0);
  // Leaving IDLE and resync both start a fresh bit at this sample.
  assign restart = ~busy | resync;

  always_comb begin
    first_nxt = 1'b0;
    last_nxt  = 1'b0;
    cnt_nxt   = cnt;
    unique case (1'b1)
      restart: begin
        first_nxt = 1'b1;
        cnt_nxt   = CNT_W'(1);
      end
      (~restart & (cnt == LAST_CNT)): begin
        last_nxt = 1'b1;
        cnt_nxt  = '0;
      end
      default: begin
        first_nxt = (cnt == '0);
        cnt_nxt   = cnt + 1'b1;
      end
    endcase
  end

  // Low 32 bits of a 32x32 product of sign-extended 16-bit values
  // equal the exact 16x16 signed product.
  assign rx_x     = {{16{rx_sig[15]}}, rx_sig};
  assign car_x    = {{16{carrier_sig[15]}}, carrier_sig};
  assign prod_nxt = rx_x * car_x;

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      prod     <= '0;
      sync_err <= 1'b0;
    end else begin
      s1_vld   <= accept;
      sync_err <= accept & resync;
      if (accept) begin
        state    <= RUN;
        cnt      <= cnt_nxt;
        s1_first <= first_nxt;
        s1_last  <= last_nxt;
        prod     <= prod_nxt;
      end
    end
  end

  assign prod_x = {{(ACC_W-32){prod[31]}}, prod};
  // A first product overwrites acc, which drops any partial bit.
  assign sum = s1_first ? prod_x : acc + prod_x;

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      demod_bit   <= 1'b0;
      demod_valid <= 1'b0;
    end else begin
      demod_valid <= s1_vld & s1_last;
      if (s1_vld) begin
        acc <= sum;
        if (s1_last) demod_bit <= ~sum[ACC_W-1];
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demod.sv
// Self-checking bench for bpsk_demod: sample-level reference model
// plus directed bits and a randomized tail.
module tb_bpsk_demod;

  localparam int SPB = 32;

  logic        clk_sig = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        bit_sync = 1'b0;
  logic [15:0] rx_sig = '0;
  logic [15:0] carrier_sig = '0;
  logic        demod_bit;
  logic        demod_valid;
  logic        sync_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scnt = 0;

  bit dq[$];
  int cq[$];

  bpsk_demod #(
    .SAMPLES_PER_BIT(SPB),
    .ACC_W(40)
  ) dut (
    .clk_sig(clk_sig),
    .rst_n(rst_n),
    .sample_en(sample_en),
    .rx_sig(rx_sig),
    .carrier_sig(carrier_sig),
    .bit_sync(bit_sync),
    .demod_bit(demod_bit),
    .demod_valid(demod_valid),
    .sync_err(sync_err),
    .busy(busy)
  );

  always #5 clk_sig = ~clk_sig;

  always @(posedge clk_sig) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: samples counted within a bit, products summed
  // in a 64-bit integer, decisions delayed to their visible cycle.
  bit     m_run = 0;
  int     m_pos = 0;
  longint m_sum = 0;
  longint last_sum = 0;
  bit     p_valid = 0;
  bit     p_bit = 0;
  bit     e_valid = 0;
  bit     e_bit = 0;
  bit     e_sync = 0;

  always @(posedge clk_sig or negedge rst_n) begin
    longint pr;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_sum = 0;
      p_valid = 0; p_bit = 0;
      e_valid = 0; e_bit = 0; e_sync = 0;
    end else begin
      e_valid = p_valid;
      e_bit = p_bit;
      p_valid = 0;
      e_sync = 0;
      if (sample_en && (m_run || bit_sync)) begin
        pr = longint'($signed(rx_sig)) * longint'($signed(carrier_sig));
        if (bit_sync && m_run && m_pos != 0) e_sync = 1;
        if (bit_sync || m_pos == 0) begin
          m_pos = 0;
          m_sum = 0;
        end
        m_run = 1;
        m_sum += pr;
        m_pos++;
        if (m_pos == SPB) begin
          p_valid = 1;
          p_bit = (m_sum >= 0);
          last_sum = m_sum;
          m_pos = 0;
        end
      end
    end
  end

  always @(negedge clk_sig) begin
    check("valid", demod_valid, e_valid);
    check("sync_err", sync_err, e_sync);
    check("busy", busy, m_run);
    if (e_valid) check("bit", demod_bit, e_bit);
    if (demod_valid === 1'b1) begin
      dq.push_back(demod_bit);
      cq.push_back(cyc);
    end
    if (sync_err === 1'b1) scnt++;
  end

  function automatic logic gb(input int i);
    if (i < dq.size()) return dq[i];
    return 1'bx;
  endfunction

  function automatic int gc(input int i);
    if (i < cq.size()) return cq[i];
    return -1;
  endfunction

  task automatic step(input bit en, input int rx,
                      input int car, input bit sy);
    sample_en = en;
    rx_sig = 16'(rx);
    carrier_sig = 16'(car);
    bit_sync = sy;
    @(posedge clk_sig);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic clr();
    dq.delete();
    cq.delete();
  endtask

  int car_tab[8] = '{0, 7071, 10000, 7071, 0, -7071, -10000, -7071};
  bit pat[5] = '{1, 0, 1, 1, 0};

  initial begin
    int last;
    int s;
    int c;
    int rx;
    int n;
    int s0;
    bit d;

    repeat (3) @(posedge clk_sig);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 0);
    check("idle_busy", busy, 0);
    check("idle_count", dq.size(), 0);

    clr();
    step(1, 500, 1000, 1);
    for (int i = 1; i < SPB; i++) step(1, 500, 1000, 0);
    last = cyc;
    idle(4);
    check("pos_count", dq.size(), 1);
    check("pos_bit", gb(0), 1);
    check("pos_sum", last_sum, 64'd16000000);
    check("pos_latency", gc(0), last + 1);

    clr();
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < SPB; k++) begin
        c = car_tab[k % 8];
        n = $urandom_range(0, 400) - 200;
        rx = (pat[b] ? c : -c) + n;
        step(1, rx, c, k == 0);
      end
    idle(4);
    check("alt_count", dq.size(), 5);
    for (int b = 0; b < 5; b++) check("alt_bit", gb(b), pat[b]);
    for (int b = 0; b < 4; b++)
      check("alt_spacing", gc(b + 1) - gc(b), SPB);

    clr();
    s = 0;
    for (int i = 0; i < 2 * SPB; i++) begin
      if (i % 2 == 0) step(1, 500, 1000, i == 0);
      else step(0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (i == 0) s = cyc;
    end
    idle(4);
    check("gap_count", dq.size(), 1);
    check("gap_bit", gb(0), 1);
    check("gap_sum", last_sum, 64'd16000000);
    check("gap_latency", gc(0), s + 2 * SPB - 1);

    clr();
    s0 = scnt;
    d = 1'($urandom_range(0, 1));
    for (int i = 0; i < 10; i++) step(1, $urandom, $urandom, i == 0);
    for (int i = 0; i < SPB; i++) begin
      n = $urandom_range(1000, 2000);
      step(1, d ? n : -n, $urandom_range(500, 1500), i == 0);
    end
    idle(4);
    check("rs_sync_err", scnt - s0, 1);
    check("rs_count", dq.size(), 1);
    check("rs_bit", gb(0), d);

    clr();
    for (int i = 0; i < SPB; i++) step(1, -32768, -32768, i == 0);
    idle(3);
    check("ext_count", dq.size(), 1);
    check("ext_bit", gb(0), 1);
    check("ext_sum", last_sum, 64'd34359738368);

    for (int i = 0; i < 20; i++) step(1, $urandom, $urandom, i == 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", demod_valid, 0);
    check("rst_bit", demod_bit, 0);
    check("rst_sync_err", sync_err, 0);
    repeat (2) @(negedge clk_sig);
    #1;
    rst_n = 1'b1;
    n = dq.size();
    for (int i = 0; i < 40; i++) step(1, $urandom, $urandom, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_count", dq.size(), n);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 49) == 0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
